// File: rtl/ahb_lite_cmd_master.sv
// Single-transfer AHB-Lite initiator: one command in, one non-pipelined bus transfer, one response out.
// Latency cmd->rsp_valid is 3 cycles plus one per hready=0 cycle; cmd_ready is low while a command is in flight.
module ahb_lite_cmd_master #(
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [1:0]  cmd_size,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_err,
   output logic        busy,
   output logic [31:0] haddr,
   output logic [1:0]  htrans,
   output logic        hwrite,
   output logic [2:0]  hsize,
   output logic [2:0]  hburst,
   output logic [3:0]  hprot,
   output logic        hmastlock,
   output logic [31:0] hwdata,
   input  logic        hready,
   input  logic        hresp,
   input  logic [31:0] hrdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_RESP = 2'd3
   } state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] ERR_OKAY      = 2'b00;
   localparam logic [1:0] ERR_BUS       = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

   state_e      state_q, state_d;
   logic [31:0] addr_q,  addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  size_q,  size_d;
   logic [1:0]  err_q,   err_d;
   logic        write_q, write_d;

   logic        cmd_hs;
   logic        cmd_bad;
   logic [31:0] wdata_lane;
   logic [31:0] rdata_lane;

   assign cmd_hs = cmd_valid && (state_q == S_IDLE);

   // Misaligned or reserved-size commands are answered locally and never reach the bus.
   always_comb begin
      cmd_bad = 1'b0;
      case (cmd_size)
         2'd0:    cmd_bad = 1'b0;
         2'd1:    cmd_bad = cmd_addr[0];
         2'd2:    cmd_bad = (cmd_addr[1:0] != 2'b00);
         default: cmd_bad = 1'b1;
      endcase
   end

   always_comb begin
      wdata_lane = cmd_wdata;
      case (cmd_size)
         2'd0:    wdata_lane = {4{cmd_wdata[7:0]}};
         2'd1:    wdata_lane = {2{cmd_wdata[15:0]}};
         default: wdata_lane = cmd_wdata;
      endcase
   end

   always_comb begin
      rdata_lane = hrdata;
      case (size_q)
         2'd0: begin
            case (addr_q[1:0])
               2'd0:    rdata_lane = {24'h0, hrdata[7:0]};
               2'd1:    rdata_lane = {24'h0, hrdata[15:8]};
               2'd2:    rdata_lane = {24'h0, hrdata[23:16]};
               default: rdata_lane = {24'h0, hrdata[31:24]};
            endcase
         end
         2'd1:    rdata_lane = addr_q[1] ? {16'h0, hrdata[31:16]} : {16'h0, hrdata[15:0]};
         default: rdata_lane = hrdata;
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (cmd_hs) state_d = cmd_bad ? S_RESP : S_ADDR;
         S_ADDR: if (hready) state_d = S_DATA;
         S_DATA: if (hready) state_d = S_RESP;
         S_RESP: if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      rsp_valid = (state_q == S_RESP);
      htrans    = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
   end

   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      size_d  = size_q;
      err_d   = err_q;
      write_d = write_q;
      if (cmd_hs) begin
         addr_d  = cmd_addr;
         size_d  = cmd_size;
         write_d = cmd_write;
         wdata_d = wdata_lane;
         if (cmd_bad) begin
            err_d   = ERR_ILLEGAL;
            rdata_d = 32'h0;
         end
      end else if ((state_q == S_DATA) && hready) begin
         // Only the hready=1 edge ends the data phase; an hresp-only cycle just waits.
         if (hresp) begin
            err_d   = ERR_BUS;
            rdata_d = 32'h0;
         end else begin
            err_d   = ERR_OKAY;
            rdata_d = write_q ? 32'h0 : rdata_lane;
         end
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         size_q  <= 2'd0;
         err_q   <= ERR_OKAY;
         write_q <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         size_q  <= size_d;
         err_q   <= err_d;
         write_q <= write_d;
      end
   end

   assign haddr     = addr_q;
   assign hwrite    = write_q;
   assign hsize     = {1'b0, size_q};
   assign hwdata    = wdata_q;
   assign hburst    = 3'b000;
   assign hprot     = HPROT_VAL;
   assign hmastlock = 1'b0;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Directed bench for ahb_lite_cmd_master: reactive AHB slave, response scoreboard, cycle-level bus checks.
module tb_ahb_lite_cmd_master;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [1:0]  cmd_size;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic        busy;
   logic [31:0] haddr, hwdata, hrdata;
   logic [1:0]  htrans;
   logic        hwrite, hmastlock, hready, hresp;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;

   int vectors = 0;
   int miscompares = 0;
   logic [33:0] sb_q[$];

   // slave configuration for the next transfer
   int          slv_wait = 0;
   logic        slv_err = 1'b0;
   logic [31:0] slv_rdata = 32'h0;
   logic        dp_active = 1'b0;
   int          dp_cnt = 0;

   always #5 hclk = ~hclk;

   ahb_lite_cmd_master #(.HPROT_VAL(4'b0011)) dut (
      .hclk(hclk), .hresetn(hresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy),
      .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
      .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
      .hready(hready), .hresp(hresp), .hrdata(hrdata)
   );

   always @(posedge hclk) begin
      if (htrans == 2'b10 && hready) begin
         dp_active <= 1'b1;
         dp_cnt    <= slv_wait;
      end else if (dp_active && hready) begin
         dp_active <= 1'b0;
      end else if (dp_active) begin
         dp_cnt <= dp_cnt - 1;
      end
   end

   assign hready = !dp_active || (dp_cnt == 0);
   assign hresp  = dp_active && slv_err && (dp_cnt <= 1);
   assign hrdata = (dp_active && dp_cnt == 0) ? slv_rdata : 32'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   always @(negedge hclk) begin
      if (hresetn && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_unexpected: got response %h/%h, expected none", rsp_rdata, rsp_err);
         end else begin
            logic [33:0] e;
            e = sb_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e[33:2]);
            chk("rsp_err", {30'h0, rsp_err}, {30'h0, e[1:0]});
         end
      end
   end

   task automatic do_cmd(input string nm, input logic wr, input logic [31:0] addr,
                         input logic [1:0] sz, input logic [31:0] wd,
                         input int wt, input logic er, input logic [31:0] srd,
                         input logic [31:0] exp_rd, input logic [1:0] exp_err,
                         input int exp_lat, input logic [31:0] exp_hw, input int hold);
      logic legal;
      logic seen;
      int   lat;
      legal = (exp_err != 2'b11);
      @(posedge hclk); #1;
      slv_wait  = wt;
      slv_err   = er;
      slv_rdata = srd;
      rsp_ready = (hold == 0);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_size  = sz;
      cmd_wdata = wd;
      @(negedge hclk);
      chk({nm, "_cmd_ready"}, {31'h0, cmd_ready}, 32'h1);
      @(posedge hclk); #1;
      cmd_valid = 1'b0;
      cmd_wdata = 32'h0;
      sb_q.push_back({exp_rd, exp_err});
      seen = 1'b0;
      lat  = 0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge hclk);
         if (rsp_valid) begin
            seen = 1'b1;
            lat  = k;
         end else if (legal) begin
            chk({nm, "_haddr"}, haddr, addr);
            if (k == 1) begin
               chk({nm, "_htrans_nonseq"}, {30'h0, htrans}, 32'h2);
               chk({nm, "_hsize"}, {29'h0, hsize}, {30'h0, sz});
               chk({nm, "_hwrite"}, {31'h0, hwrite}, {31'h0, wr});
            end else begin
               chk({nm, "_htrans_idle"}, {30'h0, htrans}, 32'h0);
               if (wr) chk({nm, "_hwdata"}, hwdata, exp_hw);
            end
         end
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got no rsp_valid, expected one within 40 cycles", nm);
      end else begin
         chk({nm, "_latency"}, lat, exp_lat);
         chk({nm, "_cmd_ready_resp"}, {31'h0, cmd_ready}, 32'h0);
         if (!legal) chk({nm, "_htrans_nobus"}, {30'h0, htrans}, 32'h0);
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge hclk);
         chk({nm, "_rsp_held"}, {31'h0, rsp_valid}, 32'h1);
         chk({nm, "_rsp_err_stable"}, {30'h0, rsp_err}, {30'h0, exp_err});
      end
      if (hold > 0) begin
         @(posedge hclk); #1;
         rsp_ready = 1'b1;
      end
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge hclk);
         if (!rsp_valid) seen = 1'b1;
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_rsp_drop: got rsp_valid stuck 1, expected 0 after handshake", nm);
      end
   endtask

   initial begin
      hresetn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0;
      cmd_size  = 2'd0;
      cmd_wdata = 32'h0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge hclk);
      #1 hresetn = 1'b1;
      @(negedge hclk);
      chk("rst_htrans", {30'h0, htrans}, 32'h0);
      chk("rst_haddr", haddr, 32'h0);
      chk("rst_hwrite", {31'h0, hwrite}, 32'h0);
      chk("rst_hsize", {29'h0, hsize}, 32'h0);
      chk("rst_hwdata", hwdata, 32'h0);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", {30'h0, rsp_err}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      chk("const_hburst", {29'h0, hburst}, 32'h0);
      chk("const_hprot", {28'h0, hprot}, 32'h3);
      chk("const_hmastlock", {31'h0, hmastlock}, 32'h0);

      //      name        wr    addr          sz    wdata         wt er    slave rdata   exp rdata     err    lat hwdata       hold
      do_cmd("wr_word",   1'b1, 32'h6000_0010, 2'd2, 32'hDEAD_BEEF, 0, 1'b0, 32'h0,        32'h0,        2'b00, 3, 32'hDEAD_BEEF, 0);
      do_cmd("rd_byte",   1'b0, 32'h6000_0003, 2'd0, 32'h0,         2, 1'b0, 32'h1234_5678, 32'h0000_0012, 2'b00, 5, 32'h0,        0);
      do_cmd("wr_half",   1'b1, 32'h6000_0002, 2'd1, 32'h0000_ABCD, 0, 1'b0, 32'h0,        32'h0,        2'b00, 3, 32'hABCD_ABCD, 0);
      do_cmd("rd_err",    1'b0, 32'h6000_0008, 2'd2, 32'h0,         1, 1'b1, 32'hCAFE_F00D, 32'h0,        2'b01, 4, 32'h0,        0);
      do_cmd("rd_after",  1'b0, 32'h6000_0004, 2'd2, 32'h0,         0, 1'b0, 32'h89AB_CDEF, 32'h89AB_CDEF, 2'b00, 3, 32'h0,        0);
      do_cmd("misalign",  1'b0, 32'h6000_0002, 2'd2, 32'h0,         0, 1'b0, 32'h0,        32'h0,        2'b11, 1, 32'h0,        0);
      do_cmd("size3",     1'b1, 32'h6000_0000, 2'd3, 32'h1111_2222, 0, 1'b0, 32'h0,        32'h0,        2'b11, 1, 32'h0,        0);
      do_cmd("rd_hold",   1'b0, 32'h6000_0002, 2'd1, 32'h0,         0, 1'b0, 32'h1234_5678, 32'h0000_1234, 2'b00, 3, 32'h0,        5);

      // reset pulsed while the address phase is on the bus
      @(posedge hclk); #1;
      slv_wait  = 0;
      slv_err   = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h6000_0020;
      cmd_size  = 2'd2;
      @(posedge hclk); #1;
      cmd_valid = 1'b0;
      @(negedge hclk);
      chk("rst_mid_nonseq", {30'h0, htrans}, 32'h2);
      #1 hresetn = 1'b0;
      #1;
      chk("rst_mid_htrans", {30'h0, htrans}, 32'h0);
      chk("rst_mid_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      chk("rst_mid_busy", {31'h0, busy}, 32'h0);
      chk("rst_mid_haddr", haddr, 32'h0);
      @(posedge hclk); #1;
      hresetn = 1'b1;

      do_cmd("wr_byte",   1'b1, 32'h6000_0001, 2'd0, 32'h0000_00A5, 0, 1'b0, 32'h0,        32'h0,        2'b00, 3, 32'hA5A5_A5A5, 0);

      repeat (2) @(negedge hclk);
      chk("sb_drained", sb_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
